gray_counter_ud: RTL and testbench

Parametrised up/down Gray-code counter with enable, Gray-coded synchronous load and a selectable wrap/saturate mode. It generalises the team's fixed-width, up-only registered Gray counter for use as pointer generators, for example asynchronous-FIFO read/write pointers and rotary/position trackers. Both Gray and binary views of the count are registered together, so they are always coherent. A one-cycle event flag marks wrap-around or saturation.

---
 rtl/gray_counter_ud_pkg.sv | 34 +++
 rtl/gray_counter_ud_if.sv | 29 ++
 rtl/gray_counter_ud_next.sv | 63 ++++++
 rtl/gray_counter_ud.sv | 57 +++++
 tb/tb_gray_counter_ud.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/gray_counter_ud_pkg.sv
// rtl/gray_counter_ud_pkg.sv - Gray/binary conversion helpers shared by the Gray counter
//
// Package gray_pkg: width-generic conversion functions operating on a
// GRAY_MAX_W-bit word. Callers zero-extend narrower values in and truncate
// the result back to their own width. Both conversions are bit-local from the
// MSB down, so zero-extension leaves the low bits of the result unchanged.
//   bin2gray(b)  : b ^ (b >> 1)
//   gray2bin(g)  : prefix-XOR from the MSB
//   max_count(w) : 2^w - 1, the largest w-bit unsigned count

package gray_pkg;

    localparam int GRAY_MAX_W = 32;

    typedef logic [GRAY_MAX_W-1:0] gray_word_t;

    function automatic gray_word_t bin2gray(input gray_word_t b);
        return b ^ (b >> 1);
    endfunction

    function automatic gray_word_t gray2bin(input gray_word_t g);
        gray_word_t b;
        b[GRAY_MAX_W-1] = g[GRAY_MAX_W-1];
        for (int i = GRAY_MAX_W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    function automatic gray_word_t max_count(input int w);
        return (w >= GRAY_MAX_W) ? '1 : ((gray_word_t'(1) << w) - gray_word_t'(1));
    endfunction

endpackage

// File: rtl/gray_counter_ud_if.sv
// rtl/gray_counter_ud_if.sv - control/status bundle of the up/down Gray counter
//
// Signals:
//   en, dir, load, load_val : controls, driven by the master (counter user)
//   out, bin, wrap          : registered status, driven by the slave (counter)

interface gray_counter_ud_if #(
    parameter int DATA_WIDTH = 4
);

    logic                  en;
    logic                  dir;
    logic                  load;
    logic [DATA_WIDTH-1:0] load_val;
    logic [DATA_WIDTH-1:0] out;
    logic [DATA_WIDTH-1:0] bin;
    logic                  wrap;

    modport master (
        output en, dir, load, load_val,
        input  out, bin, wrap
    );

    modport slave (
        input  en, dir, load, load_val,
        output out, bin, wrap
    );

endinterface

// File: rtl/gray_counter_ud_next.sv
// rtl/gray_counter_ud_next.sv - combinational next-state logic of the up/down Gray counter
//
// Ports:
//   bin        in  current binary count
//   en, dir    in  step enable and direction (1 = up)
//   load       in  load strobe, overrides en/dir
//   load_val   in  Gray-coded load value
//   next_bin   out binary count for the next edge
//   next_gray  out Gray encoding of next_bin
//   next_wrap  out step wrapped (SATURATE=0) or was clamped (SATURATE=1)

module gray_counter_ud_next
    import gray_pkg::*;
#(
    parameter int DATA_WIDTH = 4,
    parameter int SATURATE   = 0
) (
    input  logic [DATA_WIDTH-1:0] bin,
    input  logic                  en,
    input  logic                  dir,
    input  logic                  load,
    input  logic [DATA_WIDTH-1:0] load_val,
    output logic [DATA_WIDTH-1:0] next_bin,
    output logic [DATA_WIDTH-1:0] next_gray,
    output logic                  next_wrap
);

    localparam logic [DATA_WIDTH-1:0] MAX = DATA_WIDTH'(max_count(DATA_WIDTH));
    localparam bit                    SAT = (SATURATE != 0);

    always_comb begin
        next_bin  = bin;
        next_wrap = 1'b0;
        next_gray = DATA_WIDTH'(bin2gray(gray_word_t'(bin)));

        if (load) begin
            next_bin  = DATA_WIDTH'(gray2bin(gray_word_t'(load_val)));
            // Every Gray word decodes uniquely, so load_val is already the
            // encoding of next_bin.
            next_gray = load_val;
        end else if (en) begin
            if (dir) begin
                if (bin == MAX) begin
                    next_wrap = 1'b1;
                    if (!SAT) next_bin = '0;
                end else begin
                    next_bin = bin + DATA_WIDTH'(1);
                end
            end else begin
                if (bin == '0) begin
                    next_wrap = 1'b1;
                    if (!SAT) next_bin = MAX;
                end else begin
                    next_bin = bin - DATA_WIDTH'(1);
                end
            end
            // Encode from the new binary value, never from the old one, so
            // out and bin stay coherent on every edge.
            next_gray = DATA_WIDTH'(bin2gray(gray_word_t'(next_bin)));
        end
    end

endmodule

// File: rtl/gray_counter_ud.sv
// rtl/gray_counter_ud.sv - parametrised up/down Gray counter with load and wrap/saturate
//
// Ports:
//   clk    in   rising-edge clock
//   reset  in   asynchronous active-high reset
//   cnt    slave modport of gray_counter_ud_if:
//            en, dir, load, load_val in; out (Gray), bin (binary), wrap out
// Parameters: DATA_WIDTH (>= 2, <= 32), RESET_VALUE (binary, truncated),
//             SATURATE (0 = wrap modulo 2^DATA_WIDTH, 1 = clamp at the limits)

module gray_counter_ud
    import gray_pkg::*;
#(
    parameter int DATA_WIDTH  = 4,
    parameter int RESET_VALUE = 0,
    parameter int SATURATE    = 0
) (
    input  logic                clk,
    input  logic                reset,
    gray_counter_ud_if.slave    cnt
);

    localparam logic [DATA_WIDTH-1:0] RST_BIN  = DATA_WIDTH'(RESET_VALUE);
    localparam logic [DATA_WIDTH-1:0] RST_GRAY = DATA_WIDTH'(bin2gray(gray_word_t'(RST_BIN)));

    logic [DATA_WIDTH-1:0] next_bin;
    logic [DATA_WIDTH-1:0] next_gray;
    logic                  next_wrap;

    gray_counter_ud_next #(
        .DATA_WIDTH (DATA_WIDTH),
        .SATURATE   (SATURATE)
    ) u_next (
        .bin       (cnt.bin),
        .en        (cnt.en),
        .dir       (cnt.dir),
        .load      (cnt.load),
        .load_val  (cnt.load_val),
        .next_bin  (next_bin),
        .next_gray (next_gray),
        .next_wrap (next_wrap)
    );

    // bin, out and wrap share one register stage so both views always agree.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt.bin  <= RST_BIN;
            cnt.out  <= RST_GRAY;
            cnt.wrap <= 1'b0;
        end else begin
            cnt.bin  <= next_bin;
            cnt.out  <= next_gray;
            cnt.wrap <= next_wrap;
        end
    end

endmodule

// File: tb/tb_gray_counter_ud.sv
// tb/tb_gray_counter_ud.sv - self-checking bench for gray_counter_ud (wrap, saturate, reset value)

module tb_gray_counter_ud;

    logic       clk;
    logic       reset;
    logic       en;
    logic       dir;
    logic       load;
    logic [3:0] load_val;

    int checks = 0;
    int errors = 0;

    // dut0: wrap, reset 0; dut1: saturate, reset 0; dut2: wrap, reset 5
    gray_counter_ud_if #(.DATA_WIDTH(4)) if0 ();
    gray_counter_ud_if #(.DATA_WIDTH(4)) if1 ();
    gray_counter_ud_if #(.DATA_WIDTH(4)) if2 ();

    assign if0.en = en;  assign if0.dir = dir;  assign if0.load = load;  assign if0.load_val = load_val;
    assign if1.en = en;  assign if1.dir = dir;  assign if1.load = load;  assign if1.load_val = load_val;
    assign if2.en = en;  assign if2.dir = dir;  assign if2.load = load;  assign if2.load_val = load_val;

    gray_counter_ud #(.DATA_WIDTH(4), .RESET_VALUE(0), .SATURATE(0)) dut0 (.clk(clk), .reset(reset), .cnt(if0));
    gray_counter_ud #(.DATA_WIDTH(4), .RESET_VALUE(0), .SATURATE(1)) dut1 (.clk(clk), .reset(reset), .cnt(if1));
    gray_counter_ud #(.DATA_WIDTH(4), .RESET_VALUE(5), .SATURATE(0)) dut2 (.clk(clk), .reset(reset), .cnt(if2));

    logic [3:0] a_out [3];
    logic [3:0] a_bin [3];
    logic       a_wrap[3];

    assign a_out[0] = if0.out;  assign a_bin[0] = if0.bin;  assign a_wrap[0] = if0.wrap;
    assign a_out[1] = if1.out;  assign a_bin[1] = if1.bin;  assign a_wrap[1] = if1.wrap;
    assign a_out[2] = if2.out;  assign a_bin[2] = if2.bin;  assign a_wrap[2] = if2.wrap;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: plain integer count per DUT.
    int m_bin [3];
    int m_wrap[3];

    function automatic int sat_of(input int k);
        return (k == 1) ? 1 : 0;
    endfunction

    function automatic int rv_of(input int k);
        return (k == 2) ? 5 : 0;
    endfunction

    function automatic int gray_of(input int b);
        return b ^ (b >> 1);
    endfunction

    // Decode by search: the unique count whose Gray code equals g.
    function automatic int decode(input int g);
        for (int b = 0; b < 16; b++) begin
            if (gray_of(b) == g) return b;
        end
        return -1;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            m_bin[k]  = rv_of(k);
            m_wrap[k] = 0;
        end
    endtask

    task automatic model_edge();
        for (int k = 0; k < 3; k++) begin
            m_wrap[k] = 0;
            if (reset) begin
                m_bin[k] = rv_of(k);
            end else if (load) begin
                m_bin[k] = decode(int'(load_val));
            end else if (en) begin
                if (dir) begin
                    if (m_bin[k] == 15) begin
                        m_wrap[k] = 1;
                        m_bin[k]  = sat_of(k) ? 15 : 0;
                    end else begin
                        m_bin[k] = m_bin[k] + 1;
                    end
                end else begin
                    if (m_bin[k] == 0) begin
                        m_wrap[k] = 1;
                        m_bin[k]  = sat_of(k) ? 0 : 15;
                    end else begin
                        m_bin[k] = m_bin[k] - 1;
                    end
                end
            end
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_model(input string tag);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("%s dut%0d out", tag, k), 32'(a_out[k]), 32'(gray_of(m_bin[k])));
            chk($sformatf("%s dut%0d bin", tag, k), 32'(a_bin[k]), 32'(m_bin[k]));
            chk($sformatf("%s dut%0d wrap", tag, k), 32'(a_wrap[k]), 32'(m_wrap[k]));
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic async_reset_pulse();
        reset = 1'b1;
        #1;
        model_reset();
        reset = 1'b0;
    endtask

    typedef struct {
        logic       ld;
        logic       e;
        logic       d;
        logic [3:0] lv;
        logic [3:0] xo;
        logic [3:0] xb;
        logic       xw;
    } vec_t;

    vec_t vt[10];
    int   gray_up[16];
    logic [3:0] prev;
    int   wraps0;
    int   wraps1;

    initial begin
        reset = 1'b1; en = 1'b0; dir = 1'b0; load = 1'b0; load_val = 4'h0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_model("reset");
        chk("reset dut2 out", 32'(a_out[2]), 32'h7);
        chk("reset dut2 bin", 32'(a_bin[2]), 32'h5);
        reset = 1'b0;

        // dut0 vectors, applied from bin 0: ld, en, dir, load_val -> out, bin, wrap
        vt[0] = '{1'b0, 1'b1, 1'b0, 4'b0000, 4'b1000, 4'd15, 1'b1};
        vt[1] = '{1'b0, 1'b1, 1'b0, 4'b0000, 4'b1001, 4'd14, 1'b0};
        vt[2] = '{1'b1, 1'b1, 1'b1, 4'b1100, 4'b1100, 4'd8,  1'b0};
        vt[3] = '{1'b0, 1'b1, 1'b1, 4'b0000, 4'b1101, 4'd9,  1'b0};
        vt[4] = '{1'b1, 1'b0, 1'b0, 4'b0101, 4'b0101, 4'd6,  1'b0};
        vt[5] = '{1'b0, 1'b0, 1'b1, 4'b0000, 4'b0101, 4'd6,  1'b0};
        vt[6] = '{1'b1, 1'b0, 1'b0, 4'b1000, 4'b1000, 4'd15, 1'b0};
        vt[7] = '{1'b0, 1'b1, 1'b1, 4'b0000, 4'b0000, 4'd0,  1'b1};
        vt[8] = '{1'b0, 1'b1, 1'b1, 4'b0000, 4'b0001, 4'd1,  1'b0};
        vt[9] = '{1'b0, 1'b1, 1'b0, 4'b0000, 4'b0000, 4'd0,  1'b0};
        for (int i = 0; i < 10; i++) begin
            load = vt[i].ld; en = vt[i].e; dir = vt[i].d; load_val = vt[i].lv;
            tick();
            chk($sformatf("vec%0d out", i), 32'(a_out[0]), 32'(vt[i].xo));
            chk($sformatf("vec%0d bin", i), 32'(a_bin[0]), 32'(vt[i].xb));
            chk($sformatf("vec%0d wrap", i), 32'(a_wrap[0]), 32'(vt[i].xw));
            check_model($sformatf("vec%0d", i));
        end
        load = 1'b0;

        // Up-count through the wrap; dut1 clamps instead.
        gray_up = '{1, 3, 2, 6, 7, 5, 4, 12, 13, 15, 14, 10, 11, 9, 8, 0};
        async_reset_pulse();
        en = 1'b1; dir = 1'b1;
        wraps0 = 0; wraps1 = 0;
        for (int i = 0; i < 20; i++) begin
            prev = a_out[0];
            tick();
            if (i < 16) begin
                chk($sformatf("up%0d gray", i), 32'(a_out[0]), 32'(gray_up[i]));
                chk($sformatf("up%0d onebit", i), 32'($countones(prev ^ a_out[0])), 32'd1);
            end
            wraps0 += int'(a_wrap[0]);
            wraps1 += int'(a_wrap[1]);
            check_model($sformatf("up%0d", i));
        end
        chk("wrap pulses dut0", 32'(wraps0), 32'd1);
        chk("sat pulses dut1", 32'(wraps1), 32'd5);
        chk("sat hold out", 32'(a_out[1]), 32'b1000);
        dir = 1'b0;
        tick();
        chk("sat reverse bin", 32'(a_bin[1]), 32'd14);
        check_model("sat reverse");

        // Asynchronous reset between edges while dut2 sits at 11.
        async_reset_pulse();
        dir = 1'b1;
        repeat (6) tick();
        chk("pre-reset dut2 bin", 32'(a_bin[2]), 32'd11);
        en = 1'b0;
        #3;
        reset = 1'b1;
        #1;
        model_reset();
        chk("async dut2 out", 32'(a_out[2]), 32'b0111);
        chk("async dut2 bin", 32'(a_bin[2]), 32'd5);
        chk("async dut2 wrap", 32'(a_wrap[2]), 32'd0);
        check_model("async");
        reset = 1'b0;

        // Hold at bin 6.
        load = 1'b1; load_val = 4'b0101;
        tick();
        load = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk($sformatf("hold%0d out", i), 32'(a_out[0]), 32'b0101);
            chk($sformatf("hold%0d wrap", i), 32'(a_wrap[0]), 32'd0);
        end
        check_model("hold");

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            load     = ($urandom_range(0, 9) == 0);
            en       = ($urandom_range(0, 3) != 0);
            dir      = 1'($urandom);
            load_val = 4'($urandom);
            if ($urandom_range(0, 49) == 0) begin
                #2;
                async_reset_pulse();
            end
            tick();
            check_model($sformatf("rand%0d", i));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
